panel_bus_master: RTL and testbench
===================================

Name: panel_bus_master

Overview:
- Front-panel memory access engine; it is the initiator side of the 6502 external memory bus.
- cpu_control answers 6502 cycles as a responder. This block instead drives address, data, R/W and RAM chip-select itself, so the keypad (examine, store/inc, dec) can read and write system RAM while the 6502 is halted.
- Sits between keyboard/command logic and the board bus pins. The top level muxes its outputs onto A, D, RAM_csN and Drive6502BusN.

Parameters:
- TURN_CYCLES, 4: clk cycles after bus_drive_n asserts before the address is driven (transceiver turnaround).
- SETUP_CYCLES, 3: address/RW/data stable before RAM_csN asserts.
- STROBE_CYCLES, 5: RAM_csN low time; read data is sampled on the last strobe cycle.
- HOLD_CYCLES, 2: address/data held after RAM_csN deasserts.

Ports:
- clk  in  1  25 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- grant  in  1  bus may be taken (6502 stopped); level
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0=LOAD_ADDR, 1=READ, 2=WRITE_INC, 3=DEC_ADDR
- cmd_addr  in  16  address for LOAD_ADDR
- cmd_wdata  in  8  data for WRITE_INC
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse, coincident with done, if grant was lost during a bus cycle
- ptr  out  16  current address pointer
- rdata  out  8  last byte read
- bus_drive_n  out  1  low = FPGA owns bus (to Drive6502BusN)
- a_out  out  16  address to bus
- a_oe  out  1  address output enable
- d_out  out  8  write data
- d_oe  out  1  data output enable
- d_in  in  8  bus data, already synchronised
- rw_out  out  1  1=read, 0=write
- ram_cs_n  out  1  RAM chip select, active low

Behaviour:
- Reset values (asynchronous, immediate):
  - cmd_ready=1, done=0, err=0, ptr=0x0000, rdata=0x00.
  - bus_drive_n=1, a_oe=0, d_oe=0, a_out=0, d_out=0, rw_out=1, ram_cs_n=1.
  - Reset mid-cycle releases the bus the same instant; no completion pulse.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE; commands offered while busy are not latched.
- Pointer commands:
  - LOAD_ADDR and DEC_ADDR do not touch the bus.
  - ptr updates the cycle after acceptance; done pulses that same cycle.
  - ptr arithmetic is 16-bit modulo: 0xFFFF+1=0x0000, 0x0000-1=0xFFFF.
- Bus commands (READ, WRITE_INC) state machine:
  - IDLE -> ACQUIRE on accept; bus_drive_n=0.
  - ACQUIRE: wait for grant. Once grant=1, count TURN_CYCLES, then -> SETUP. If grant never rises, remain in ACQUIRE; there is no timeout.
  - SETUP: a_oe=1, a_out=ptr; rw_out=1 for READ, 0 for WRITE_INC; for WRITE_INC also d_oe=1, d_out=wdata. SETUP_CYCLES -> STROBE.
  - STROBE: ram_cs_n=0 for STROBE_CYCLES. READ latches rdata=d_in on the final strobe cycle. -> HOLD.
  - HOLD: ram_cs_n=1; address, data and rw_out held for HOLD_CYCLES. -> RELEASE.
  - RELEASE (1 cycle): a_oe=0, d_oe=0, rw_out=1, bus_drive_n=1; done pulses. WRITE_INC increments ptr here. -> IDLE.
- Timing:
  - Enables never change in the same cycle as ram_cs_n. d_oe is never 1 while rw_out=1.
  - Bus command latency with grant already high at accept: TURN+SETUP+STROBE+HOLD+2 cycles, i.e. 16 cycles from the accept edge to done with defaults.
- grant dropping after ACQUIRE:
  - The cycle completes normally; no abort mid-strobe.
  - err pulses with done. The pointer still increments for WRITE_INC.
- Any counter parameter set to 0 is treated as 1.

Decomposition:
- Shared package panel_bus_pkg:
  - cmd_op encodings: OP_LOAD_ADDR, OP_READ, OP_WRITE_INC, OP_DEC_ADDR.
  - State enum: IDLE, ACQUIRE, SETUP, STROBE, HOLD, RELEASE.
  - Default timing constants.
- One sub-module is natural: phase_timer, a loadable down-counter with a zero flag. It is reused across the four timed states.

Test Plan:
- LOAD_ADDR 0x1234 -> ptr=0x1234 the next cycle, done for 1 cycle, bus_drive_n stays 1 throughout.
- grant=1; WRITE_INC with ptr=0x0200, data=0xA5:
  - Bus shows a_out=0x0200, rw_out=0, d_out=0xA5.
  - ram_cs_n is low exactly 5 cycles.
  - done arrives 16 cycles after accept; ptr becomes 0x0201.
- Bus model returns 0x5A at 0x0201; READ -> rdata=0x5A, ptr unchanged at 0x0201, d_oe never 1.
- ptr=0xFFFF, WRITE_INC -> write lands at 0xFFFF, ptr=0x0000. Then DEC_ADDR -> ptr=0xFFFF.
- grant=0 at accept:
  - Remains in ACQUIRE with cmd_ready=0 for 50 cycles.
  - Raising grant completes the cycle normally.
  - Dropping grant during STROBE -> cycle completes, err and done pulse together.
- rst_n asserted during STROBE -> ram_cs_n=1, a_oe=0, bus_drive_n=1 without waiting for a clock edge; after release, cmd_ready=1 and ptr=0x0000.

Source files
------------

// File: rtl/panel_bus_pkg.sv
// Shared types and timing defaults for the front-panel bus initiator.
// Holds command encodings, FSM states and the phase-length helper.
package panel_bus_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_ADDR = 2'd0,
    OP_READ      = 2'd1,
    OP_WRITE_INC = 2'd2,
    OP_DEC_ADDR  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    SETUP,
    STROBE,
    HOLD,
    RELEASE
  } state_e;

  localparam int unsigned TMR_W = 8;

  localparam int unsigned DEF_TURN_CYCLES   = 4;
  localparam int unsigned DEF_SETUP_CYCLES  = 3;
  localparam int unsigned DEF_STROBE_CYCLES = 5;
  localparam int unsigned DEF_HOLD_CYCLES   = 2;

  // A zero-length phase would never leave its state, so it is stretched to one cycle.
  function automatic logic [TMR_W-1:0] phase_len(input int unsigned cycles);
    int unsigned c;
    c = (cycles == 0) ? 1 : cycles;
    if (c > 255) c = 255;
    return c[TMR_W-1:0];
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by the timed bus phases.
// Loading N gives a zero flag after N-1 further cycles, so a phase lasts N cycles.
module phase_timer
  import panel_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  localparam logic [TMR_W-1:0] ONE = 1;

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val - ONE;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/panel_bus_master.sv
// Front-panel initiator on the 6502 memory bus: pointer commands plus
// single read / write-and-increment cycles while the CPU is halted.
module panel_bus_master
  import panel_bus_pkg::*;
#(
  parameter int unsigned TURN_CYCLES   = DEF_TURN_CYCLES,
  parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        grant,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        done,
  output logic        err,
  output logic [15:0] ptr,
  output logic [7:0]  rdata,
  output logic        bus_drive_n,
  output logic [15:0] a_out,
  output logic        a_oe,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        rw_out,
  output logic        ram_cs_n
);

  localparam logic [TMR_W-1:0] TURN_LEN   = phase_len(TURN_CYCLES);
  localparam logic [TMR_W-1:0] SETUP_LEN  = phase_len(SETUP_CYCLES);
  localparam logic [TMR_W-1:0] STROBE_LEN = phase_len(STROBE_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_LEN   = phase_len(HOLD_CYCLES);

  state_e      state_q;
  logic        is_read_q, turning_q, grant_lost_q;
  logic [7:0]  wdata_q;
  logic        cmd_ready_q, done_q, err_q;
  logic [15:0] ptr_q, a_out_q;
  logic [7:0]  rdata_q, d_out_q;
  logic        bus_drive_n_q, a_oe_q, d_oe_q, rw_out_q, ram_cs_n_q;

  logic             tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic             accept;
  op_e              op;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready_q;

  // Turnaround counting starts on the first cycle grant is seen high.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TURN_LEN;
    case (state_q)
      ACQUIRE: begin
        if (!turning_q && grant) begin
          tmr_load = 1'b1;
          tmr_val  = TURN_LEN;
        end else if (turning_q && tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LEN;
        end
      end
      SETUP: begin
        tmr_load = tmr_zero;
        tmr_val  = STROBE_LEN;
      end
      STROBE: begin
        tmr_load = tmr_zero;
        tmr_val  = HOLD_LEN;
      end
      default: ;
    endcase
  end

  phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      is_read_q     <= 1'b0;
      turning_q     <= 1'b0;
      grant_lost_q  <= 1'b0;
      wdata_q       <= 8'h00;
      cmd_ready_q   <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      ptr_q         <= 16'h0000;
      rdata_q       <= 8'h00;
      bus_drive_n_q <= 1'b1;
      a_oe_q        <= 1'b0;
      d_oe_q        <= 1'b0;
      a_out_q       <= 16'h0000;
      d_out_q       <= 8'h00;
      rw_out_q      <= 1'b1;
      ram_cs_n_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_LOAD_ADDR: begin
                ptr_q  <= cmd_addr;
                done_q <= 1'b1;
              end
              OP_DEC_ADDR: begin
                ptr_q  <= ptr_q - 16'd1;
                done_q <= 1'b1;
              end
              default: begin
                is_read_q     <= (op == OP_READ);
                wdata_q       <= cmd_wdata;
                turning_q     <= 1'b0;
                grant_lost_q  <= 1'b0;
                cmd_ready_q   <= 1'b0;
                bus_drive_n_q <= 1'b0;
                state_q       <= ACQUIRE;
              end
            endcase
          end
        end
        ACQUIRE: begin
          if (!turning_q) begin
            if (grant) turning_q <= 1'b1;
          end else if (tmr_zero) begin
            state_q  <= SETUP;
            a_oe_q   <= 1'b1;
            a_out_q  <= ptr_q;
            rw_out_q <= is_read_q;
            d_oe_q   <= !is_read_q;
            if (!is_read_q) d_out_q <= wdata_q;
          end
        end
        SETUP: begin
          if (!grant) grant_lost_q <= 1'b1;
          if (tmr_zero) begin
            state_q    <= STROBE;
            ram_cs_n_q <= 1'b0;
          end
        end
        STROBE: begin
          if (!grant) grant_lost_q <= 1'b1;
          if (tmr_zero) begin
            state_q    <= HOLD;
            ram_cs_n_q <= 1'b1;
            if (is_read_q) rdata_q <= d_in;
          end
        end
        HOLD: begin
          if (!grant) grant_lost_q <= 1'b1;
          if (tmr_zero) begin
            state_q       <= RELEASE;
            a_oe_q        <= 1'b0;
            d_oe_q        <= 1'b0;
            rw_out_q      <= 1'b1;
            bus_drive_n_q <= 1'b1;
          end
        end
        RELEASE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          done_q      <= 1'b1;
          err_q       <= grant_lost_q;
          if (!is_read_q) ptr_q <= ptr_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ptr         = ptr_q;
  assign rdata       = rdata_q;
  assign bus_drive_n = bus_drive_n_q;
  assign a_out       = a_out_q;
  assign a_oe        = a_oe_q;
  assign d_out       = d_out_q;
  assign d_oe        = d_oe_q;
  assign rw_out      = rw_out_q;
  assign ram_cs_n    = ram_cs_n_q;

endmodule

// File: tb/tb_panel_bus_master.sv
// Scoreboard bench for panel_bus_master: directed commands, a RAM model on
// the bus side, and monitors that check completions and bus strobes.
module tb_panel_bus_master;
  import panel_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        grant = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        cmd_ready, done, err, bus_drive_n, a_oe, d_oe, rw_out, ram_cs_n;
  logic [15:0] ptr, a_out;
  logic [7:0]  rdata, d_out, d_in;

  logic [7:0] mem [0:65535];
  assign d_in = mem[a_out];

  panel_bus_master dut (
    .clk(clk), .rst_n(rst_n), .grant(grant),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .done(done), .err(err), .ptr(ptr), .rdata(rdata),
    .bus_drive_n(bus_drive_n), .a_out(a_out), .a_oe(a_oe),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
    .rw_out(rw_out), .ram_cs_n(ram_cs_n)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  int viol_doe = 0, viol_en = 0, viol_err = 0;

  typedef struct {
    logic [15:0] ptr;
    logic [7:0]  rdata;
    logic        err;
    int          done_cyc;
    string       name;
  } sb_t;
  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
  } bus_t;

  sb_t  sb_q[$];
  bus_t bus_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Completion monitor
  always @(negedge clk) begin : done_mon
    sb_t e;
    if (rst_n) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_ptr"}, {16'd0, ptr}, {16'd0, e.ptr});
          check({e.name, "_rdata"}, {24'd0, rdata}, {24'd0, e.rdata});
          check({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
          if (e.done_cyc >= 0) check({e.name, "_latency"}, cyc, e.done_cyc);
        end
      end else if (err) begin
        viol_err++;
      end
    end
  end

  // Strobe monitor: also acts as the RAM write port
  int          cs_cnt = 0;
  logic [15:0] cap_a;
  logic        cap_rw;
  logic [7:0]  cap_d;
  always @(negedge clk) begin : bus_mon
    bus_t b;
    if (!rst_n) begin
      cs_cnt = 0;
    end else if (!ram_cs_n) begin
      cs_cnt++;
      cap_a  = a_out;
      cap_rw = rw_out;
      cap_d  = d_out;
    end else if (cs_cnt != 0) begin
      if (bus_q.size() == 0) begin
        check("unexpected_strobe", cs_cnt, 0);
      end else begin
        b = bus_q.pop_front();
        check("strobe_len", cs_cnt, 5);
        check("bus_addr", {16'd0, cap_a}, {16'd0, b.addr});
        check("bus_rw", {31'd0, cap_rw}, {31'd0, b.rw});
        if (!b.rw) check("bus_wdata", {24'd0, cap_d}, {24'd0, b.data});
      end
      if (!cap_rw) mem[cap_a] = cap_d;
      cs_cnt = 0;
    end
  end

  logic pa_oe = 1'b0, pd_oe = 1'b0, pcs = 1'b1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (d_oe && rw_out) viol_doe++;
      if (((a_oe != pa_oe) || (d_oe != pd_oe)) && (ram_cs_n != pcs)) viol_en++;
    end
    pa_oe = a_oe;
    pd_oe = d_oe;
    pcs   = ram_cs_n;
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd,
                       input string name, input logic [15:0] eptr, input logic [7:0] erd,
                       input logic eerr, input int lat);
    int t0;
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check({name, "_ready_timeout"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    t0 = cyc;
    sb_q.push_back('{eptr, erd, eerr, (lat < 0) ? -1 : t0 + 1 + lat, name});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 300);
    if (!cmd_ready) check({name, "_idle_timeout"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic wait_cs_low(input string name);
    int n;
    n = 0;
    while (ram_cs_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ram_cs_n) check({name, "_cs_timeout"}, {31'd0, ram_cs_n}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int v;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0201] = 8'h5A;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ptr", {16'd0, ptr}, 32'h0000);
    check("rst_rdata", {24'd0, rdata}, 32'h00);
    check("rst_bus_drive_n", {31'd0, bus_drive_n}, 32'd1);
    check("rst_a_oe", {31'd0, a_oe}, 32'd0);
    check("rst_d_oe", {31'd0, d_oe}, 32'd0);
    check("rst_rw_out", {31'd0, rw_out}, 32'd1);
    check("rst_ram_cs_n", {31'd0, ram_cs_n}, 32'd1);
    check("rst_a_out", {16'd0, a_out}, 32'h0000);
    check("rst_d_out", {24'd0, d_out}, 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    grant = 1'b1;

    issue(OP_LOAD_ADDR, 16'h1234, 8'h00, "load_1234", 16'h1234, 8'h00, 1'b0, 0);
    v = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_drive_n !== 1'b1) v++;
    end
    check("load_bus_untouched", v, 0);

    issue(OP_LOAD_ADDR, 16'h0200, 8'h00, "load_0200", 16'h0200, 8'h00, 1'b0, 0);
    wait_idle("load_0200");
    bus_q.push_back('{16'h0200, 1'b0, 8'hA5});
    issue(OP_WRITE_INC, 16'h0000, 8'hA5, "write_a5", 16'h0201, 8'h00, 1'b0, 16);
    wait_idle("write_a5");
    check("mem_0200", {24'd0, mem[16'h0200]}, 32'hA5);

    bus_q.push_back('{16'h0201, 1'b1, 8'h00});
    issue(OP_READ, 16'h0000, 8'h00, "read_0201", 16'h0201, 8'h5A, 1'b0, 16);
    wait_idle("read_0201");

    issue(OP_LOAD_ADDR, 16'hFFFF, 8'h00, "load_ffff", 16'hFFFF, 8'h5A, 1'b0, 0);
    wait_idle("load_ffff");
    bus_q.push_back('{16'hFFFF, 1'b0, 8'h3C});
    issue(OP_WRITE_INC, 16'h0000, 8'h3C, "write_wrap", 16'h0000, 8'h5A, 1'b0, 16);
    wait_idle("write_wrap");
    check("mem_ffff", {24'd0, mem[16'hFFFF]}, 32'h3C);
    issue(OP_DEC_ADDR, 16'h0000, 8'h00, "dec_wrap", 16'hFFFF, 8'h5A, 1'b0, 0);
    wait_idle("dec_wrap");

    // No grant: engine must sit in ACQUIRE owning nothing but the transceiver
    grant = 1'b0;
    bus_q.push_back('{16'hFFFF, 1'b1, 8'h00});
    issue(OP_READ, 16'h0000, 8'h00, "read_late_grant", 16'hFFFF, 8'h3C, 1'b0, -1);
    v = 0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || bus_drive_n !== 1'b0 || ram_cs_n !== 1'b1 || a_oe !== 1'b0) v++;
    end
    check("acquire_wait", v, 0);
    grant = 1'b1;
    wait_idle("read_late_grant");

    issue(OP_LOAD_ADDR, 16'h0400, 8'h00, "load_0400", 16'h0400, 8'h3C, 1'b0, 0);
    wait_idle("load_0400");
    bus_q.push_back('{16'h0400, 1'b0, 8'h77});
    issue(OP_WRITE_INC, 16'h0000, 8'h77, "write_grant_lost", 16'h0401, 8'h3C, 1'b1, 16);
    wait_cs_low("write_grant_lost");
    grant = 1'b0;
    wait_idle("write_grant_lost");
    grant = 1'b1;

    // Reset in the middle of a strobe
    issue(OP_LOAD_ADDR, 16'h0500, 8'h00, "load_0500", 16'h0500, 8'h3C, 1'b0, 0);
    wait_idle("load_0500");
    issue(OP_READ, 16'h0000, 8'h00, "read_reset", 16'h0500, 8'h00, 1'b0, 16);
    wait_cs_low("read_reset");
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("arst_ram_cs_n", {31'd0, ram_cs_n}, 32'd1);
    check("arst_a_oe", {31'd0, a_oe}, 32'd0);
    check("arst_bus_drive_n", {31'd0, bus_drive_n}, 32'd1);
    check("arst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_ptr", {16'd0, ptr}, 32'h0000);

    issue(OP_DEC_ADDR, 16'h0000, 8'h00, "dec_zero", 16'hFFFF, 8'h00, 1'b0, 0);
    wait_idle("dec_zero");
    repeat (3) @(negedge clk);

    check("d_oe_with_read", viol_doe, 0);
    check("enable_vs_cs_same_cycle", viol_en, 0);
    check("err_without_done", viol_err, 0);
    check("sb_leftover", sb_q.size(), 0);
    check("bus_leftover", bus_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
